// File: rtl/motor_pkg.sv
// Shared definitions for motor-channel blocks: FSM state encodings, default duty width
// and helpers used by the PWM sequencer and its neighbours.
package motor_pkg;

    localparam int unsigned DW_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    typedef logic [DW_DEFAULT-1:0] duty_t;

    // Duty is in motion while ramping toward the target or winding down to zero.
    function automatic logic is_busy(input state_e s);
        return (s == ST_RAMP) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter with a registered boundary flag that is high exactly
// while the counter holds its maximum value.
module pwm_period_counter
    import motor_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    output logic [DW-1:0] counter,
    output logic          bnd
);

    localparam logic [DW-1:0] MAX = '1;

    logic [DW-1:0] cnt_q, cnt_d;
    logic          bnd_q, bnd_d;

    always_comb begin
        cnt_d = cnt_q + DW'(1);
        // Flag is computed from the next count so it lines up with counter == MAX.
        bnd_d = (cnt_d == MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            bnd_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bnd_q <= bnd_d;
        end
    end

    assign counter = cnt_q;
    assign bnd     = bnd_q;

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start/soft-stop sequencer for one PWM channel: steps the applied duty one LSB at a
// time toward a latched target, only on PWM period boundaries.
module pwm_ramp_sequencer
    import motor_pkg::*;
#(
    parameter int unsigned DW           = DW_DEFAULT,
    parameter int unsigned STEP_PERIODS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] duty,
    output logic [DW-1:0] counter,
    output logic [DW-1:0] dc,
    output logic          pwm,
    output logic          busy,
    output logic [1:0]    state
);

    localparam int unsigned SCW     = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SCW-1:0] SC_LAST = SCW'(STEP_PERIODS - 1);

    state_e         state_q, state_d;
    logic [DW-1:0]  dc_q, dc_d;
    logic [DW-1:0]  tgt_q, tgt_d;
    logic [SCW-1:0] sc_q, sc_d;
    logic           pwm_q, pwm_d;

    logic [DW-1:0]  cnt;
    logic           bnd;
    logic [DW-1:0]  tgt_nxt;
    logic [DW-1:0]  goal;
    logic [DW-1:0]  dc_step;
    logic           step_fire;

    pwm_period_counter #(
        .DW(DW)
    ) u_period (
        .clk    (clk),
        .rst    (rst),
        .counter(cnt),
        .bnd    (bnd)
    );

    always_comb begin
        tgt_nxt   = (en && (duty != '0)) ? duty : tgt_q;
        goal      = (state_q == ST_STOP) ? '0 : tgt_nxt;
        step_fire = (sc_q == SC_LAST);
        // One LSB toward the goal; equality holds, so the step saturates without wrap.
        if (dc_q < goal) begin
            dc_step = dc_q + DW'(1);
        end else if (dc_q > goal) begin
            dc_step = dc_q - DW'(1);
        end else begin
            dc_step = dc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        tgt_d   = tgt_q;
        sc_d    = sc_q;
        if (bnd) begin
            tgt_d = tgt_nxt;
            if (state_q == ST_IDLE) begin
                sc_d = '0;
                dc_d = '0;
            end else begin
                sc_d = step_fire ? '0 : sc_q + SCW'(1);
                if (step_fire) begin
                    dc_d = dc_step;
                end
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (en && (tgt_nxt != '0)) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    if (!en) begin
                        state_d = ST_STOP;
                    end else if (dc_d == tgt_nxt) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
                ST_STOP: begin
                    if (en) begin
                        state_d = ST_RAMP;
                    end else if (dc_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Compare uses the pre-edge dc, so a new duty shows up from counter 0 of the next period.
    always_comb begin
        pwm_d = (cnt < dc_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dc_q    <= '0;
            tgt_q   <= '0;
            sc_q    <= '0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dc_q    <= dc_d;
            tgt_q   <= tgt_d;
            sc_q    <= sc_d;
            pwm_q   <= pwm_d;
        end
    end

    assign counter = cnt;
    assign dc      = dc_q;
    assign pwm     = pwm_q;
    assign busy    = is_busy(state_q);
    assign state   = state_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed scenarios plus random en/duty
// segments, every cycle compared against a period-level behavioural model.
module tb_pwm_ramp_sequencer;

    localparam int DW   = 3;
    localparam int SP   = 2;
    localparam int MAXC = 7;
    localparam int IDLE = 0;
    localparam int RAMP = 1;
    localparam int RUN  = 2;
    localparam int STOP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] duty;
    logic [2:0] counter;
    logic [2:0] dc;
    logic       pwm;
    logic       busy;
    logic [1:0] state;

    always #5 clk = ~clk;

    pwm_ramp_sequencer #(
        .DW          (DW),
        .STEP_PERIODS(SP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .duty   (duty),
        .counter(counter),
        .dc     (dc),
        .pwm    (pwm),
        .busy   (busy),
        .state  (state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: counter position, applied duty, target, periods since last step, phase.
    int m_cnt, m_dc, m_tgt, m_sc, m_st, m_pwm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_dc = 0; m_tgt = 0; m_sc = 0; m_st = IDLE; m_pwm = 0;
    endtask

    // One clock of the model, given the inputs held across that edge.
    task automatic model_edge(input int e, input int d);
        int  tn;
        int  goal;
        bit  fire;
        m_pwm = (m_cnt < m_dc) ? 1 : 0;
        if (m_cnt == MAXC) begin
            tn    = (e != 0 && d != 0) ? d : m_tgt;
            m_tgt = tn;
            if (m_st == IDLE) begin
                m_sc = 0;
                m_dc = 0;
                if (e != 0 && tn != 0) m_st = RAMP;
            end else begin
                fire = (m_sc == SP - 1);
                m_sc = fire ? 0 : m_sc + 1;
                goal = (m_st == STOP) ? 0 : tn;
                if (fire) begin
                    if (goal > m_dc) m_dc = m_dc + 1;
                    else if (goal < m_dc) m_dc = m_dc - 1;
                end
                if (m_st == STOP) m_st = (e != 0) ? RAMP : ((m_dc == 0) ? IDLE : STOP);
                else m_st = (e == 0) ? STOP : ((m_dc == tn) ? RUN : RAMP);
            end
        end
        m_cnt = (m_cnt + 1) % (MAXC + 1);
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_counter"}, counter, m_cnt);
        check({pfx, "_dc"}, dc, m_dc);
        check({pfx, "_pwm"}, pwm, m_pwm);
        check({pfx, "_state"}, state, m_st);
        check({pfx, "_busy"}, busy, (m_st == RAMP || m_st == STOP) ? 1 : 0);
    endtask

    // Called at a negedge; drives inputs, advances one clock, checks at the next negedge.
    task automatic cyc(input int e, input int d);
        en   = e[0];
        duty = d[2:0];
        model_edge(e, d);
        @(posedge clk);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic run(input int n, input int e, input int d);
        for (int i = 0; i < n; i++) cyc(e, d);
    endtask

    task automatic wait_dc(input int target, input int e, input int d, input int limit);
        for (int i = 0; i < limit && m_dc != target; i++) cyc(e, d);
        check("reach_dc", dc, target);
    endtask

    task automatic pwm_window(input int e, input int d, output int hi);
        hi = 0;
        for (int i = 0; i < MAXC + 1; i++) begin
            cyc(e, d);
            hi += int'(pwm);
        end
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic rst_mid();
        #2;
        rst = 1'b1;
        #1;
        check("rst_counter", counter, 0);
        check("rst_dc", dc, 0);
        check("rst_pwm", pwm, 0);
        check("rst_state", state, IDLE);
        check("rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        int e;
        int d;
        int len;
        rst  = 1'b1;
        en   = 1'b0;
        duty = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("init");
        rst = 1'b0;

        // Reset mid-clock after some activity
        run(13, 1, 3);
        rst_mid();
        check_all("post_rst");

        // Ramp up to 5, then steady RUN
        wait_dc(5, 1, 5, 200);
        run(16, 1, 5);
        check("ramp_state", state, RUN);
        check("ramp_dc", dc, 5);
        check("ramp_busy", busy, 0);
        pwm_window(1, 5, hi);
        check("ramp_pwm_hi", hi, 5);

        // duty=0 with en=1 keeps the stored target
        run(48, 1, 0);
        check("hold_dc", dc, 5);
        check("hold_state", state, RUN);

        // Ramp down to IDLE
        run(120, 0, 0);
        check("stop_state", state, IDLE);
        check("stop_dc", dc, 0);
        pwm_window(0, 0, hi);
        check("stop_pwm_hi", hi, 0);

        // Resume from STOP at dc=3 and retarget
        wait_dc(5, 1, 5, 200);
        run(16, 1, 5);
        wait_dc(3, 0, 0, 200);
        check("resume_stop", state, STOP);
        for (int i = 0; i < MAXC + 1 && m_cnt != 0; i++) cyc(0, 0);
        run(64, 1, 2);
        check("retgt_dc", dc, 2);
        check("retgt_state", state, RUN);
        run(160, 1, 7);
        check("max_dc", dc, 7);
        check("max_state", state, RUN);
        pwm_window(1, 7, hi);
        check("max_pwm_hi", hi, 7);

        // Reset mid-ramp loses the target
        run(80, 0, 0);
        wait_dc(3, 1, 5, 200);
        run(3, 1, 5);
        rst_mid();
        run(64, 1, 0);
        check("lost_tgt_state", state, IDLE);
        check("lost_tgt_dc", dc, 0);

        // Random segments of en/duty, with occasional mid-clock resets
        for (int s = 0; s < 60; s++) begin
            e   = ($urandom_range(0, 3) != 0) ? 1 : 0;
            d   = int'($urandom_range(0, 7));
            len = int'($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) rst_mid();
            run(len, e, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
